// File: rtl/vz_loader_pkg.sv
// Shared definitions for the VZ image loader.
//   state_t      : loader FSM states
//   MAGIC_*      : expected header signature bytes ("VZF0" / "VZFO")
//   HDR_LEN      : header length in bytes; file data starts at this offset
//   TYPE_*       : VZ type byte codes (BASIC / binary)
//   DEF_*        : default BASIC pointer-pair addresses
package vz_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_PTR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  MAGIC_0      = 8'h56;
    localparam logic [7:0]  MAGIC_1      = 8'h5A;
    localparam logic [7:0]  MAGIC_2      = 8'h46;
    localparam logic [7:0]  MAGIC_3A     = 8'h30;
    localparam logic [7:0]  MAGIC_3B     = 8'h4F;

    localparam logic [15:0] HDR_LEN      = 16'd24;

    localparam logic [7:0]  TYPE_BASIC   = 8'hF0;
    localparam logic [7:0]  TYPE_BIN     = 8'hF1;

    localparam logic [15:0] DEF_PTR_BASE = 16'h78A4;
    localparam logic [15:0] DEF_END_PTR  = 16'h78F9;

    // Signature check for header offsets 0-3; every other offset passes.
    function automatic logic magic_ok(input logic [15:0] addr, input logic [7:0] data);
        case (addr)
            16'd0:   magic_ok = (data == MAGIC_0);
            16'd1:   magic_ok = (data == MAGIC_1);
            16'd2:   magic_ok = (data == MAGIC_2);
            16'd3:   magic_ok = (data == MAGIC_3A) || (data == MAGIC_3B);
            default: magic_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/vz_loader.sv
// VZ image loader: parses a .VZ file streamed over the download port,
// writes its payload to RAM through a single-entry request/ack port, and
// for BASIC images patches the BASIC start/end pointer pairs afterwards.
// Ports:
//   clk_sys, reset           : clock, asynchronous active-high reset
//   dn_download/index/addr/
//   dn_data/dn_wr            : download stream (dn_wr is a one-cycle strobe)
//   mem_req/addr/dout, mem_ack : RAM write request, held until acknowledged
//   cpu_hold, led            : high while a load is in progress
//   done                     : one-cycle pulse on successful load
//   err                      : sticky error, cleared at next download start
//   ftype, start_addr, end_addr : parsed header info / end of loaded data
module vz_loader
    import vz_loader_pkg::*;
#(
    parameter logic [7:0]  VZ_INDEX       = 8'd1,
    parameter logic [15:0] BASIC_PTR_BASE = DEF_PTR_BASE,
    parameter logic [15:0] BASIC_END_PTR  = DEF_END_PTR
)(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        dn_wr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic        mem_ack,
    output logic        cpu_hold,
    output logic        led,
    output logic        done,
    output logic        err,
    output logic [7:0]  ftype,
    output logic [15:0] start_addr,
    output logic [15:0] end_addr
);

    state_t      state;
    logic        dl_prev;
    logic        start_pend;
    logic [15:0] data_count;
    logic [1:0]  ptr_idx;
    logic        dl_rise;

    always_comb begin
        dl_rise = dn_download && !dl_prev && (dn_index == VZ_INDEX);
    end

    // mem_req/mem_addr/mem_dout form the holding register: full while mem_req.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            // Treat the line as already high so a download still in flight
            // when reset is released is not mistaken for a new start.
            dl_prev    <= 1'b1;
            start_pend <= 1'b0;
            data_count <= '0;
            ptr_idx    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_dout   <= '0;
            cpu_hold   <= 1'b0;
            led        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ftype      <= '0;
            start_addr <= '0;
            end_addr   <= '0;
        end else begin
            dl_prev <= dn_download;
            done    <= 1'b0;

            // Retire the outstanding write in whatever state we are in.
            if (mem_req && mem_ack)
                mem_req <= 1'b0;

            case (state)
                S_IDLE: begin
                    start_pend <= 1'b0;
                    if (dl_rise || (start_pend && dn_download)) begin
                        state      <= S_HDR;
                        err        <= 1'b0;
                        data_count <= '0;
                        cpu_hold   <= 1'b1;
                        led        <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (dn_wr) begin
                        case (dn_addr)
                            16'd21:  ftype <= dn_data;
                            16'd22:  start_addr[7:0] <= dn_data;
                            default: ;
                        endcase
                    end
                    // A final header byte arriving with the falling edge is
                    // still accepted before the short-file check.
                    if (dn_wr && !magic_ok(dn_addr, dn_data)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (dn_wr && dn_addr == HDR_LEN - 16'd1) begin
                        start_addr[15:8] <= dn_data;
                        end_addr         <= {dn_data, start_addr[7:0]};
                        state            <= S_DATA;
                    end else if (!dn_download) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (dn_wr && dn_addr >= HDR_LEN) begin
                        if (mem_req) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            mem_req    <= 1'b1;
                            mem_addr   <= start_addr + (dn_addr - HDR_LEN);
                            mem_dout   <= dn_data;
                            end_addr   <= start_addr + data_count + 16'd1;
                            data_count <= data_count + 16'd1;
                        end
                    end else if (!dn_download && !mem_req) begin
                        if (ftype == TYPE_BASIC) begin
                            state   <= S_PTR;
                            ptr_idx <= '0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_PTR: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                        case (ptr_idx)
                            2'd0: begin mem_addr <= BASIC_PTR_BASE;         mem_dout <= start_addr[7:0];  end
                            2'd1: begin mem_addr <= BASIC_PTR_BASE + 16'd1; mem_dout <= start_addr[15:8]; end
                            2'd2: begin mem_addr <= BASIC_END_PTR;          mem_dout <= end_addr[7:0];    end
                            default: begin mem_addr <= BASIC_END_PTR + 16'd1; mem_dout <= end_addr[15:8]; end
                        endcase
                    end else if (mem_ack) begin
                        if (ptr_idx == 2'd3) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            ptr_idx <= ptr_idx + 2'd1;
                        end
                    end
                end

                S_DONE: begin
                    if (dl_rise)
                        start_pend <= 1'b1;
                    state    <= S_IDLE;
                    cpu_hold <= 1'b0;
                    led      <= 1'b0;
                end

                S_ERR: begin
                    if (dl_rise)
                        start_pend <= 1'b1;
                    if (!dn_download && !mem_req) begin
                        state    <= S_IDLE;
                        cpu_hold <= 1'b0;
                        led      <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vz_loader.sv
// Scoreboard bench for vz_loader: expected RAM writes are queued as stimulus
// is issued; a monitor pops and compares on every mem_req/mem_ack handshake.
module tb_vz_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dn_download;
    logic [7:0]  dn_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_ack;
    logic        cpu_hold;
    logic        led;
    logic        done;
    logic        err;
    logic [7:0]  ftype;
    logic [15:0] start_addr;
    logic [15:0] end_addr;

    always #5 clk_sys = ~clk_sys;

    vz_loader #(
        .VZ_INDEX      (8'd1),
        .BASIC_PTR_BASE(16'h78A4),
        .BASIC_END_PTR (16'h78F9)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dn_download(dn_download),
        .dn_index   (dn_index),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_wr      (dn_wr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_ack    (mem_ack),
        .cpu_hold   (cpu_hold),
        .led        (led),
        .done       (done),
        .err        (err),
        .ftype      (ftype),
        .start_addr (start_addr),
        .end_addr   (end_addr)
    );

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          done_cnt  = 0;
    int          wr_cnt    = 0;
    int          ack_delay = 2;
    bit          ack_block = 1'b0;
    logic [23:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Arbiter model: grants one-cycle acks after ack_delay cycles of request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_ack  = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !ack_block) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: samples between edges, after the arbiter has updated mem_ack.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk_sys);
            #2;
            if (!reset) begin
                if (done) done_cnt++;
                if (mem_req && mem_ack) begin
                    wr_cnt++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %h expected none", {mem_addr, mem_dout});
                    end else begin
                        e = sb.pop_front();
                        check("write", 32'({mem_addr, mem_dout}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        dn_addr = a;
        dn_data = d;
        dn_wr   = 1'b1;
        @(negedge clk_sys);
        dn_wr   = 1'b0;
    endtask

    task automatic begin_dl();
        @(negedge clk_sys);
        dn_index    = 8'd1;
        dn_download = 1'b1;
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        dn_download = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] m2, input logic [7:0] m3,
                               input logic [7:0] ft, input logic [15:0] start);
        send(16'd0, 8'h56);
        send(16'd1, 8'h5A);
        send(16'd2, m2);
        send(16'd3, m3);
        for (int i = 4; i < 21; i++) send(16'(i), 8'h41);
        send(16'd21, ft);
        send(16'd22, start[7:0]);
        send(16'd23, start[15:8]);
    endtask

    task automatic wait_write_done();
        int t;
        t = 0;
        while (mem_req && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 100) timeout_fail("write_done");
    endtask

    task automatic send_data(input logic [15:0] off, input logic [7:0] d, input logic [15:0] exp_addr);
        sb.push_back({exp_addr, d});
        send(off, d);
        check("req_after_wr", 32'(mem_req), 32'd1);
        wait_write_done();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (cpu_hold && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 300) timeout_fail("wait_idle");
        tick(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_req"},  32'(mem_req),    32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
        check({tag, "_mem_dout"}, 32'(mem_dout),   32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),   32'd0);
        check({tag, "_led"},      32'(led),        32'd0);
        check({tag, "_done"},     32'(done),       32'd0);
        check({tag, "_err"},      32'(err),        32'd0);
        check({tag, "_ftype"},    32'(ftype),      32'd0);
        check({tag, "_start"},    32'(start_addr), 32'd0);
        check({tag, "_end"},      32'(end_addr),   32'd0);
    endtask

    initial begin
        int wr_before;
        reset       = 1'b1;
        dn_download = 1'b0;
        dn_index    = 8'd0;
        dn_addr     = '0;
        dn_data     = '0;
        dn_wr       = 1'b0;

        // Reset state
        tick(2);
        check_zero("rst");
        reset = 1'b0;
        tick(2);

        // Foreign index is ignored
        @(negedge clk_sys);
        dn_index    = 8'd2;
        dn_download = 1'b1;
        tick(3);
        check("other_index_hold", 32'(cpu_hold), 32'd0);
        dn_download = 1'b0;
        tick(2);

        // BASIC image at 7AE9, three bytes, then pointer patch
        done_cnt = 0;
        begin_dl();
        send_header(8'h46, 8'h30, 8'hF0, 16'h7AE9);
        check("f0_hold_busy", 32'(cpu_hold), 32'd1);
        check("f0_led_busy",  32'(led),      32'd1);
        send_data(16'd24, 8'h11, 16'h7AE9);
        send_data(16'd25, 8'h22, 16'h7AEA);
        send_data(16'd26, 8'h33, 16'h7AEB);
        sb.push_back({16'h78A4, 8'hE9});
        sb.push_back({16'h78A5, 8'h7A});
        sb.push_back({16'h78F9, 8'hEC});
        sb.push_back({16'h78FA, 8'h7A});
        end_dl();
        wait_idle();
        check("f0_done_cnt", 32'(done_cnt),   32'd1);
        check("f0_end",      32'(end_addr),   32'h7AEC);
        check("f0_start",    32'(start_addr), 32'h7AE9);
        check("f0_ftype",    32'(ftype),      32'hF0);
        check("f0_err",      32'(err),        32'd0);
        check("f0_sb_empty", 32'(sb.size()),  32'd0);
        check("f0_led_idle", 32'(led),        32'd0);

        // Binary image at 8000, two bytes, no pointer writes
        done_cnt = 0;
        begin_dl();
        send_header(8'h46, 8'h30, 8'hF1, 16'h8000);
        send_data(16'd24, 8'hA5, 16'h8000);
        send_data(16'd25, 8'h5A, 16'h8001);
        end_dl();
        wait_idle();
        check("f1_done_cnt", 32'(done_cnt),  32'd1);
        check("f1_ftype",    32'(ftype),     32'hF1);
        check("f1_end",      32'(end_addr),  32'h8002);
        check("f1_sb_empty", 32'(sb.size()), 32'd0);

        // Bad signature byte 2
        done_cnt  = 0;
        wr_before = wr_cnt;
        begin_dl();
        send(16'd0, 8'h56);
        send(16'd1, 8'h5A);
        send(16'd2, 8'h47);
        tick(1);
        check("bad_err",      32'(err),      32'd1);
        check("bad_req",      32'(mem_req),  32'd0);
        check("bad_hold_on",  32'(cpu_hold), 32'd1);
        end_dl();
        wait_idle();
        check("bad_hold_off", 32'(cpu_hold), 32'd0);
        check("bad_err_kept", 32'(err),      32'd1);
        check("bad_no_write", 32'(wr_cnt - wr_before), 32'd0);
        check("bad_no_done",  32'(done_cnt), 32'd0);

        // Start FFFF wraps to 0000; also the "VZFO" signature variant
        done_cnt = 0;
        begin_dl();
        tick(2);
        check("wrap_err_cleared", 32'(err), 32'd0);
        send_header(8'h46, 8'h4F, 8'hF1, 16'hFFFF);
        send_data(16'd24, 8'hC3, 16'hFFFF);
        send_data(16'd25, 8'h3C, 16'h0000);
        end_dl();
        wait_idle();
        check("wrap_end",      32'(end_addr),  32'h0001);
        check("wrap_done_cnt", 32'(done_cnt),  32'd1);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Second byte while the holding register is still full
        done_cnt  = 0;
        ack_block = 1'b1;
        begin_dl();
        send_header(8'h46, 8'h30, 8'hF1, 16'h9000);
        sb.push_back({16'h9000, 8'h77});
        send(16'd24, 8'h77);
        tick(2);
        check("ovf_req_held",  32'(mem_req),  32'd1);
        check("ovf_addr_held", 32'(mem_addr), 32'h9000);
        check("ovf_dout_held", 32'(mem_dout), 32'h77);
        send(16'd25, 8'h88);
        tick(1);
        check("ovf_err",       32'(err),     32'd1);
        check("ovf_req_still", 32'(mem_req), 32'd1);
        ack_block = 1'b0;
        wait_write_done();
        end_dl();
        wait_idle();
        check("ovf_sb_empty", 32'(sb.size()), 32'd0);
        check("ovf_no_done",  32'(done_cnt),  32'd0);
        check("ovf_err_kept", 32'(err),       32'd1);

        // Reset during DATA with a write pending
        ack_block = 1'b1;
        begin_dl();
        send_header(8'h46, 8'h30, 8'hF1, 16'hA000);
        sb.push_back({16'hA000, 8'h99});
        send(16'd24, 8'h99);
        tick(2);
        check("mid_req_pending", 32'(mem_req), 32'd1);
        @(negedge clk_sys);
        #1 reset = 1'b1;
        #1;
        check_zero("async_rst");
        sb.delete();
        dn_download = 1'b0;
        tick(2);
        reset     = 1'b0;
        ack_block = 1'b0;
        tick(3);
        check("post_rst_req",  32'(mem_req),  32'd0);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);

        done_cnt = 0;
        begin_dl();
        send_header(8'h46, 8'h30, 8'hF1, 16'h4000);
        send_data(16'd24, 8'h01, 16'h4000);
        send_data(16'd25, 8'h02, 16'h4001);
        send_data(16'd26, 8'h03, 16'h4002);
        end_dl();
        wait_idle();
        check("rl_done_cnt", 32'(done_cnt),   32'd1);
        check("rl_start",    32'(start_addr), 32'h4000);
        check("rl_end",      32'(end_addr),   32'h4003);
        check("rl_err",      32'(err),        32'd0);
        check("rl_sb_empty", 32'(sb.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
